// File: rtl/vram_cpu_port.sv
// vram_cpu_port: CPU-side initiator for LSPC VRAM accesses.
// Decodes VRAMADDR / VRAMRW / VRAMMOD strobes, issues write/read requests to
// the VRAM cycle sequencers, applies the post-write modulo increment and holds
// read data for the 68k.
// Optional feature macro: VRAM_RD_PREFETCH_EN (re-read the current word after
// every completed write so CPU_RDATA always tracks the addressed word).
module vram_cpu_port #(
  parameter logic [15:0] MOD_RESET = 16'h0001
) (
  input  logic        CLK_24M,
  input  logic        RESETP,
  input  logic        CPU_WR,
  input  logic        CPU_RD,
  input  logic [1:0]  CPU_REG,
  input  logic [15:0] CPU_DATA,
  output logic [15:0] CPU_RDATA,
  output logic        CPU_BUSY,
  output logic [15:0] VRAM_ADDR,
  output logic        REG_VRAMADDR_MSB,
  output logic [15:0] VRAM_WRITE,
  output logic        nVRAM_WRITE_REQ,
  input  logic        VRAM_WR_ACK,
  output logic        VRAM_RD_REQ,
  input  logic        VRAM_RD_ACK,
  input  logic [15:0] VRAM_LOW_READ,
  input  logic [15:0] VRAM_HIGH_READ,
  output logic [15:0] REG_VRAMMOD
);

`ifdef VRAM_RD_PREFETCH_EN
  localparam logic PREFETCH = 1'b1;
`else
  localparam logic PREFETCH = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WR_WAIT, S_RD_WAIT} state_t;

  state_t      r_state, w_state_next;
  logic [15:0] r_addr, r_mod, r_write, r_rdata;
  logic        r_buf_valid, r_shadow_valid;
  logic [15:0] r_buf_data, r_shadow_addr;

  logic        w_wr_addr, w_wr_rw, w_wr_mod, w_rw_accept;
  logic        w_load_write, w_buf_set, w_buf_clr;
  logic        w_addr_load, w_addr_inc, w_shadow_set, w_shadow_apply;
  logic        w_rdata_load;
  logic [15:0] w_write_data;
  logic        w_unused;

  // CPU_RD only selects the already-held latch; it has no side effects here.
  assign w_unused = CPU_RD;

  assign w_wr_addr   = CPU_WR && (CPU_REG == 2'd0);
  assign w_wr_rw     = CPU_WR && (CPU_REG == 2'd1);
  assign w_wr_mod    = CPU_WR && (CPU_REG == 2'd2);
  // A VRAMRW write while the buffer holds a word is dropped.
  assign w_rw_accept = w_wr_rw && !r_buf_valid;

  assign CPU_RDATA        = r_rdata;
  assign VRAM_ADDR        = r_addr;
  assign REG_VRAMADDR_MSB = r_addr[15];
  assign VRAM_WRITE       = r_write;
  assign REG_VRAMMOD      = r_mod;
  assign nVRAM_WRITE_REQ  = (r_state != S_WR_WAIT);
  assign VRAM_RD_REQ      = (r_state == S_RD_WAIT);
  assign CPU_BUSY         = (r_state == S_WR_WAIT) || r_buf_valid;

  // Next-state and datapath control decode.
  // A VRAMRW strobe landing in the acknowledge cycle is issued straight from
  // CPU_DATA, exactly as if it had already been buffered.
  always_comb begin
    w_state_next   = r_state;
    w_load_write   = 1'b0;
    w_write_data   = r_buf_data;
    w_buf_set      = 1'b0;
    w_buf_clr      = 1'b0;
    w_addr_load    = 1'b0;
    w_addr_inc     = 1'b0;
    w_shadow_set   = 1'b0;
    w_shadow_apply = 1'b0;
    w_rdata_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rw_accept) begin
          w_load_write = 1'b1;
          w_write_data = CPU_DATA;
          w_state_next = S_WR_WAIT;
        end else if (w_wr_addr) begin
          w_addr_load  = 1'b1;
          w_state_next = S_RD_WAIT;
        end
      end
      S_WR_WAIT: begin
        w_shadow_set = w_wr_addr;
        if (VRAM_WR_ACK) begin
          w_addr_inc = 1'b1;
          if (r_buf_valid) begin
            w_load_write = 1'b1;
            w_buf_clr    = 1'b1;
          end else if (w_rw_accept) begin
            w_load_write = 1'b1;
            w_write_data = CPU_DATA;
          end else if (PREFETCH) begin
            w_state_next = S_RD_WAIT;
          end else begin
            w_state_next   = S_IDLE;
            w_shadow_apply = 1'b1;
          end
        end else if (w_rw_accept) begin
          w_buf_set = 1'b1;
        end
      end
      S_RD_WAIT: begin
        w_shadow_set = w_wr_addr;
        if (VRAM_RD_ACK) begin
          w_rdata_load = 1'b1;
          if (r_buf_valid) begin
            w_load_write = 1'b1;
            w_buf_clr    = 1'b1;
            w_state_next = S_WR_WAIT;
          end else if (w_rw_accept) begin
            w_load_write = 1'b1;
            w_write_data = CPU_DATA;
            w_state_next = S_WR_WAIT;
          end else begin
            w_state_next   = S_IDLE;
            w_shadow_apply = 1'b1;
          end
        end else if (w_rw_accept) begin
          w_buf_set = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_24M) begin
    if (RESETP) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Register file, write buffer and read latch.
  always_ff @(posedge CLK_24M) begin
    if (RESETP) begin
      r_mod       <= MOD_RESET;
      r_write     <= '0;
      r_rdata     <= '0;
      r_buf_valid <= 1'b0;
      r_buf_data  <= '0;
    end else begin
      if (w_wr_mod)     r_mod   <= CPU_DATA;
      if (w_load_write) r_write <= w_write_data;
      if (w_rdata_load) r_rdata <= r_addr[15] ? VRAM_HIGH_READ : VRAM_LOW_READ;
      if (w_buf_set) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= CPU_DATA;
      end else if (w_buf_clr) begin
        r_buf_valid <= 1'b0;
      end
    end
  end

  // Address register with shadow load; a pending shadow overrides the increment.
  always_ff @(posedge CLK_24M) begin
    if (RESETP) begin
      r_addr         <= '0;
      r_shadow_valid <= 1'b0;
      r_shadow_addr  <= '0;
    end else begin
      if (w_addr_load)
        r_addr <= CPU_DATA;
      else if (w_shadow_apply && w_wr_addr)
        r_addr <= CPU_DATA;
      else if (w_shadow_apply && r_shadow_valid)
        r_addr <= r_shadow_addr;
      else if (w_addr_inc)
        r_addr[14:0] <= r_addr[14:0] + r_mod[14:0];

      if (w_shadow_apply) begin
        r_shadow_valid <= 1'b0;
      end else if (w_shadow_set) begin
        r_shadow_valid <= 1'b1;
        r_shadow_addr  <= CPU_DATA;
      end
    end
  end

endmodule

// File: tb/tb_vram_cpu_port.sv
// Directed testbench for vram_cpu_port with write/read scoreboards.
module tb_vram_cpu_port;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_wr, cpu_rd;
  logic [1:0]  cpu_reg;
  logic [15:0] cpu_data;
  logic [15:0] cpu_rdata;
  logic        cpu_busy;
  logic [15:0] vram_addr;
  logic        addr_msb;
  logic [15:0] vram_write;
  logic        n_wr_req;
  logic        wr_ack;
  logic        rd_req;
  logic        rd_ack;
  logic [15:0] low_read, high_read;
  logic [15:0] reg_mod;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         wq[$];
  logic [15:0] rq[$];
  logic [15:0] m_addr;
  logic [15:0] m_mod;

  always #5 clk = ~clk;

  vram_cpu_port #(.MOD_RESET(16'h0001)) dut (
    .CLK_24M          (clk),
    .RESETP           (rst),
    .CPU_WR           (cpu_wr),
    .CPU_RD           (cpu_rd),
    .CPU_REG          (cpu_reg),
    .CPU_DATA         (cpu_data),
    .CPU_RDATA        (cpu_rdata),
    .CPU_BUSY         (cpu_busy),
    .VRAM_ADDR        (vram_addr),
    .REG_VRAMADDR_MSB (addr_msb),
    .VRAM_WRITE       (vram_write),
    .nVRAM_WRITE_REQ  (n_wr_req),
    .VRAM_WR_ACK      (wr_ack),
    .VRAM_RD_REQ      (rd_req),
    .VRAM_RD_ACK      (rd_ack),
    .VRAM_LOW_READ    (low_read),
    .VRAM_HIGH_READ   (high_read),
    .REG_VRAMMOD      (reg_mod)
  );

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] r, input logic [15:0] d);
    cpu_wr = 1'b1; cpu_reg = r; cpu_data = d;
    cyc();
    cpu_wr = 1'b0; cpu_reg = 2'd3; cpu_data = '0;
  endtask

  task automatic set_mod(input logic [15:0] d);
    cpu_write(2'd2, d);
    m_mod = d;
  endtask

  task automatic cpu_rw(input logic [15:0] d);
    wq.push_back({m_addr, d});
    m_addr = {m_addr[15], m_addr[14:0] + m_mod[14:0]};
    cpu_write(2'd1, d);
  endtask

  // Ack the current write after it has been requested for `len` cycles.
  task automatic serve_write(input int len, input string tag);
    int  n = 0;
    wr_t e;
    while (n_wr_req !== 1'b0 && n < 50) begin cyc(); n++; end
    if (n_wr_req !== 1'b0) begin
      chk({tag, "_req_timeout"}, {15'd0, n_wr_req}, 16'h0000);
      return;
    end
    for (int i = 1; i < len; i++) begin
      chk({tag, "_req_held"}, {15'd0, n_wr_req}, 16'h0000);
      cyc();
    end
    chk({tag, "_req_last"}, {15'd0, n_wr_req}, 16'h0000);
    if (wq.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'h0001, 16'h0000 + 16'(wq.size()));
    end else begin
      e = wq.pop_front();
      chk({tag, "_wr_addr"}, vram_addr, e.addr);
      chk({tag, "_wr_data"}, vram_write, e.data);
    end
    wr_ack = 1'b1;
    cyc();
    wr_ack = 1'b0;
  endtask

  // Ack the pending read in its first request cycle and check the latch.
  task automatic serve_read(input logic [15:0] lo, input logic [15:0] hi, input string tag);
    int n = 0;
    while (rd_req !== 1'b1 && n < 50) begin cyc(); n++; end
    if (rd_req !== 1'b1) begin
      chk({tag, "_rdreq_timeout"}, {15'd0, rd_req}, 16'h0001);
      return;
    end
    rq.push_back(m_addr[15] ? hi : lo);
    low_read = lo; high_read = hi; rd_ack = 1'b1;
    cyc();
    rd_ack = 1'b0; low_read = '0; high_read = '0;
    chk({tag, "_rdreq_drop"}, {15'd0, rd_req}, 16'h0000);
    chk({tag, "_rdata"}, cpu_rdata, rq.pop_front());
    chk({tag, "_rd_addr"}, vram_addr, m_addr);
  endtask

  task automatic after_write(input logic [15:0] lo, input logic [15:0] hi, input string tag);
`ifdef VRAM_RD_PREFETCH_EN
    serve_read(lo, hi, tag);
`else
    chk({tag, "_no_prefetch"}, {15'd0, rd_req}, 16'h0000);
`endif
  endtask

  initial begin
    logic [15:0] held;
    rst = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_reg = 2'd3; cpu_data = '0;
    wr_ack = 1'b0; rd_ack = 1'b0; low_read = '0; high_read = '0;
    m_addr = '0; m_mod = 16'h0001;

    // Reset
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_addr", vram_addr, 16'h0000);
    chk("rst_mod", reg_mod, 16'h0001);
    chk("rst_write", vram_write, 16'h0000);
    chk("rst_rdata", cpu_rdata, 16'h0000);
    chk("rst_nwrreq", {15'd0, n_wr_req}, 16'h0001);
    chk("rst_rdreq", {15'd0, rd_req}, 16'h0000);
    chk("rst_busy", {15'd0, cpu_busy}, 16'h0000);
    chk("rst_msb", {15'd0, addr_msb}, 16'h0000);

    // Fast VRAM write with increment
    set_mod(16'h0001);
    chk("mod_load", reg_mod, 16'h0001);
    cpu_write(2'd0, 16'h8000); m_addr = 16'h8000;
    chk("fast_msb", {15'd0, addr_msb}, 16'h0001);
    serve_read(16'h1357, 16'h8642, "fast_rd");
    cpu_rw(16'hABCD);
    chk("fast_latency", {15'd0, n_wr_req}, 16'h0000);
    chk("fast_busy", {15'd0, cpu_busy}, 16'h0001);
    serve_write(3, "fast");
    chk("fast_req_release", {15'd0, n_wr_req}, 16'h0001);
    chk("fast_addr_inc", vram_addr, 16'h8001);
    chk("fast_write", vram_write, 16'hABCD);
    after_write(16'h0000, 16'h2468, "fast_pf");
    chk("fast_busy_clear", {15'd0, cpu_busy}, 16'h0000);

    // Wrap within 15 bits, minimum-length access
    set_mod(16'h0020);
    cpu_write(2'd0, 16'hFFF0); m_addr = 16'hFFF0;
    serve_read(16'h0000, 16'h0F0F, "wrap_rd");
    cpu_rw(16'h1234);
    serve_write(1, "wrap");
    chk("wrap_addr", vram_addr, 16'h8010);
    chk("wrap_msb", {15'd0, addr_msb}, 16'h0001);
    after_write(16'h0000, 16'h3C3C, "wrap_pf");

    // Buffered back-to-back writes, third strobe dropped while buffer full
    set_mod(16'h0004);
    cpu_write(2'd0, 16'h0010); m_addr = 16'h0010;
    serve_read(16'hC0DE, 16'h0000, "buf_rd");
    cpu_rw(16'h1111);
    cyc();
    cpu_rw(16'h2222);
    chk("buf_busy", {15'd0, cpu_busy}, 16'h0001);
    cpu_write(2'd1, 16'h3333);
    serve_write(2, "buf1");
    chk("buf_req_continuous", {15'd0, n_wr_req}, 16'h0000);
    chk("buf_busy_between", {15'd0, cpu_busy}, 16'h0001);
    serve_write(2, "buf2");
    chk("buf_req_release", {15'd0, n_wr_req}, 16'h0001);
    chk("buf_addr", vram_addr, 16'h0018);
    chk("buf_busy_clear", {15'd0, cpu_busy}, 16'h0000);
    after_write(16'h7E7E, 16'h0000, "buf_pf");
    chk("buf_drop_no_3rd", {15'd0, n_wr_req}, 16'h0001);

    // Read on address load, address unchanged; write leaves latch unless prefetch
    set_mod(16'h0001);
    cpu_write(2'd0, 16'h0100); m_addr = 16'h0100;
    serve_read(16'h5A5A, 16'hA5A5, "rd");
    chk("rd_addr_kept", vram_addr, 16'h0100);
    cpu_rw(16'h7777);
    serve_write(2, "rdw");
    after_write(16'h6B6B, 16'h0000, "rdw_pf");
`ifndef VRAM_RD_PREFETCH_EN
    chk("rd_latch_kept", cpu_rdata, 16'h5A5A);
`endif
    held = cpu_rdata;

    // Shadow address load during WR_WAIT replaces the increment
    cpu_rw(16'h4444);
    cpu_write(2'd0, 16'h0200);
    serve_write(3, "shadow");
    after_write(16'h1F1F, 16'h0000, "shadow_pf");
    m_addr = 16'h0200;
    chk("shadow_addr", vram_addr, 16'h0200);
    chk("shadow_idle", {15'd0, n_wr_req}, 16'h0001);
    held = cpu_rdata;

    // Stray acknowledges in IDLE are ignored
    wr_ack = 1'b1; rd_ack = 1'b1; low_read = 16'hDEAD; high_read = 16'hBEEF;
    cyc();
    wr_ack = 1'b0; rd_ack = 1'b0; low_read = '0; high_read = '0;
    chk("stray_addr", vram_addr, 16'h0200);
    chk("stray_rdata", cpu_rdata, held);

    // Reset in the middle of a write drops the request
    set_mod(16'h0033);
    cpu_rw(16'h9999);
    chk("midrst_req_before", {15'd0, n_wr_req}, 16'h0000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    wq.delete(); m_addr = '0; m_mod = 16'h0001;
    chk("midrst_req", {15'd0, n_wr_req}, 16'h0001);
    chk("midrst_addr", vram_addr, 16'h0000);
    chk("midrst_mod", reg_mod, 16'h0001);
    chk("midrst_busy", {15'd0, cpu_busy}, 16'h0000);

    chk("sb_wr_drained", 16'(wq.size()), 16'h0000);
    chk("sb_rd_drained", 16'(rq.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
